// File: rtl/uart_stream_ctrl_pkg.sv
// Shared UART definitions: register map, control bits, controller states, bus payload.
package uart_stream_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    // UART register addresses
    localparam logic [ADDR_W-1:0] UART_ADDR_CTRL = 3'd0;
    localparam logic [ADDR_W-1:0] UART_ADDR_RX   = 3'd1;
    localparam logic [ADDR_W-1:0] UART_ADDR_TX   = 3'd2;

    // Control register bit indices
    localparam int unsigned CTL_RX_AVAL  = 0;
    localparam int unsigned CTL_TX_BUSY  = 1;
    localparam int unsigned CTL_IRQ_ENAB = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_RD_WAIT_HI,
        ST_RD_WAIT_LO,
        ST_RD_HOLD,
        ST_EVAL,
        ST_WR,
        ST_WR_SETTLE
    } ctrl_state_e;

    // Registered UART-side bus
    typedef struct packed {
        logic              cs;
        logic              wr;
        logic              rd_strobe;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } uart_bus_t;

    localparam uart_bus_t UART_BUS_IDLE = '{
        cs: 1'b1, wr: 1'b1, rd_strobe: 1'b0, addr: UART_ADDR_CTRL, wdata: '0
    };

endpackage

// File: rtl/uart_stream_ctrl_fifo.sv
// Synchronous valid/ready FIFO with registered full/empty flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push  = in_valid && in_ready;
    assign do_pop   = out_valid && out_ready;
    assign out_data = mem[rd_ptr];

    // Occupancy after this cycle's transfers
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers, count and flags; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q   <= count_d;
            in_ready  <= (count_d != CNT_W'(DEPTH));
            out_valid <= (count_d != '0);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/uart_stream_ctrl.sv
// Polling bridge between host byte streams and a register-mapped UART.
module uart_stream_ctrl
    import uart_stream_ctrl_pkg::*;
#(
    parameter int unsigned TX_DEPTH   = 4,
    parameter int unsigned RX_DEPTH   = 4,
    parameter int unsigned RD_TIMEOUT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              u_cs,
    output logic              u_rd_strobe,
    input  logic              u_rd_busy,
    output logic              u_wr,
    output logic [ADDR_W-1:0] u_addr,
    output logic [DATA_W-1:0] u_wdata,
    input  logic [DATA_W-1:0] u_rdata,
    output logic              err_timeout
);

    localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(RD_TIMEOUT - 1);

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    uart_bus_t         bus_q, bus_d;
    logic              err_d;
    logic              tx_pop;
    logic              tx_head_valid;
    logic [DATA_W-1:0] tx_head;
    logic              rx_push;
    logic              rx_space;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (tx_valid),
        .in_ready  (tx_ready),
        .in_data   (tx_data),
        .out_valid (tx_head_valid),
        .out_ready (tx_pop),
        .out_data  (tx_head)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rx_push),
        .in_ready  (rx_space),
        .in_data   (rdata_q),
        .out_valid (rx_valid),
        .out_ready (rx_ready),
        .out_data  (rx_data)
    );

    // Next state, FIFO strobes and next UART bus value
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        tmr_d     = tmr_q;
        err_d     = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        bus_d     = UART_BUS_IDLE;

        case (state_q)
            ST_IDLE: begin
                rd_addr_d = UART_ADDR_CTRL;
                state_d   = ST_RD_STROBE;
            end
            ST_RD_STROBE: begin
                tmr_d   = '0;
                state_d = ST_RD_WAIT_HI;
            end
            ST_RD_WAIT_HI: begin
                if (u_rd_busy) begin
                    tmr_d   = '0;
                    state_d = ST_RD_WAIT_LO;
                end else if (tmr_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RD_WAIT_LO: begin
                if (!u_rd_busy) begin
                    rdata_d = u_rdata;
                    state_d = ST_RD_HOLD;
                end else if (tmr_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RD_HOLD: begin
                if (rd_addr_q == UART_ADDR_CTRL) begin
                    state_d = ST_EVAL;
                end else begin
                    rx_push = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                // Draining the UART receiver outranks transmitting; a full RX FIFO leaves the byte in the UART
                if (rdata_q[CTL_RX_AVAL] && rx_space) begin
                    rd_addr_d = UART_ADDR_RX;
                    state_d   = ST_RD_STROBE;
                end else if (!rdata_q[CTL_TX_BUSY] && tx_head_valid) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                tx_pop  = 1'b1;
                tmr_d   = '0;
                state_d = ST_WR_SETTLE;
            end
            ST_WR_SETTLE: begin
                // Two quiet cycles let the UART raise TX_BUSY before the next poll
                if (tmr_q == TMR_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_RD_STROBE: begin
                bus_d.cs        = 1'b0;
                bus_d.rd_strobe = 1'b1;
                bus_d.addr      = rd_addr_d;
            end
            ST_RD_WAIT_HI, ST_RD_WAIT_LO, ST_RD_HOLD: begin
                bus_d.cs   = 1'b0;
                bus_d.addr = rd_addr_d;
            end
            ST_WR: begin
                bus_d.cs    = 1'b0;
                bus_d.wr    = 1'b0;
                bus_d.addr  = UART_ADDR_TX;
                bus_d.wdata = tx_head;
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= UART_ADDR_CTRL;
            rdata_q     <= '0;
            tmr_q       <= '0;
            bus_q       <= UART_BUS_IDLE;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rdata_q     <= rdata_d;
            tmr_q       <= tmr_d;
            bus_q       <= bus_d;
            err_timeout <= err_d;
        end
    end

    assign u_cs        = bus_q.cs;
    assign u_wr        = bus_q.wr;
    assign u_rd_strobe = bus_q.rd_strobe;
    assign u_addr      = bus_q.addr;
    assign u_wdata     = bus_q.wdata;

endmodule

// File: tb/tb_uart_stream_ctrl.sv
// Scoreboard bench for uart_stream_ctrl with a behavioural UART model.
module tb_uart_stream_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       u_cs;
    logic       u_rd_strobe;
    logic       u_rd_busy;
    logic       u_wr;
    logic [2:0] u_addr;
    logic [7:0] u_wdata;
    logic [7:0] u_rdata;
    logic       err_timeout;

    uart_stream_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .u_cs        (u_cs),
        .u_rd_strobe (u_rd_strobe),
        .u_rd_busy   (u_rd_busy),
        .u_wr        (u_wr),
        .u_addr      (u_addr),
        .u_wdata     (u_wdata),
        .u_rdata     (u_rdata),
        .err_timeout (err_timeout)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues: data-path access order, written bytes, delivered bytes
    int         exp_acc[$];
    logic [7:0] exp_wdata[$];
    logic [7:0] exp_rx[$];

    // UART model state
    logic [7:0] uart_rx_q[$];
    int         tx_busy_cnt = 0;
    int         rd_phase    = 0;
    logic [2:0] rd_a        = 3'd0;
    bit         silent      = 1'b0;

    // Monitor counters
    int cyc = 0;
    int ctrl_strobes = 0;
    int rx_reads = 0;
    int wr_count = 0;
    int err_count = 0;
    int err_cyc = 0;
    int err_gap = 0;
    int err_cs = 0;
    int last_strobe_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: observed, expected none", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // UART model: busy for two cycles after a strobe, data presented as busy falls
    always @(negedge clock) begin
        if (tx_busy_cnt != 0) tx_busy_cnt = tx_busy_cnt - 1;
        if (rd_phase == 1) begin
            rd_phase = 2;
        end else if (rd_phase == 2) begin
            rd_phase  = 0;
            u_rd_busy = 1'b0;
            if (rd_a == 3'd1) begin
                u_rdata = (uart_rx_q.size() != 0) ? uart_rx_q.pop_front() : 8'h00;
            end else begin
                u_rdata = {6'b0, (tx_busy_cnt != 0), (uart_rx_q.size() != 0)};
            end
        end
        if (!reset && !u_cs && u_rd_strobe && !silent) begin
            u_rd_busy = 1'b1;
            rd_phase  = 1;
            rd_a      = u_addr;
        end
        if (!reset && !u_cs && !u_wr) tx_busy_cnt = 6;
    end

    // Monitor: pops the scoreboard whenever the DUT presents an access or a byte
    always @(negedge clock) begin
        if (!reset) begin
            if (!u_cs && u_rd_strobe) begin
                last_strobe_cyc = cyc;
                if (u_addr == 3'd0) begin
                    ctrl_strobes++;
                end else begin
                    rx_reads++;
                    if (exp_acc.size() == 0) flag("unexpected_read");
                    else chk("access_order", 32'(u_addr), 32'(exp_acc.pop_front()));
                end
            end
            if (!u_cs && !u_wr) begin
                wr_count++;
                if (exp_acc.size() == 0) flag("unexpected_write");
                else chk("access_order", 32'(u_addr), 32'(exp_acc.pop_front()));
                if (exp_wdata.size() != 0) chk("write_data", 32'(u_wdata), 32'(exp_wdata.pop_front()));
            end
            if (err_timeout) begin
                err_count++;
                err_gap = cyc - last_strobe_cyc;
                err_cyc = cyc;
                err_cs  = int'(u_cs);
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) flag("unexpected_rx_byte");
                else chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int r0;
        int c0;
        int n;
        int e0;
        reset     = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b0;
        u_rd_busy = 1'b0;
        u_rdata   = 8'h00;
        repeat (3) tick();

        // Reset values
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_u_cs", 32'(u_cs), 1);
        chk("rst_u_wr", 32'(u_wr), 1);
        chk("rst_u_rd_strobe", 32'(u_rd_strobe), 0);
        chk("rst_u_addr", 32'(u_addr), 0);
        chk("rst_u_wdata", 32'(u_wdata), 0);
        chk("rst_err", 32'(err_timeout), 0);
        reset = 1'b0;

        // Single transmit byte
        w0 = wr_count;
        exp_acc.push_back(2);
        exp_wdata.push_back(8'h41);
        push_tx(8'h41);
        for (int i = 0; i < 200 && wr_count == w0; i++) tick();
        repeat (60) tick();
        chk("tx_single_write_count", 32'(wr_count - w0), 1);

        // Single receive byte
        r0 = rx_reads;
        exp_acc.push_back(1);
        exp_rx.push_back(8'h5A);
        uart_rx_q.push_back(8'h5A);
        for (int i = 0; i < 200 && !rx_valid; i++) tick();
        chk("rx_valid_after_read", 32'(rx_valid), 1);
        chk("rx_head", 32'(rx_data), 32'h5A);
        chk("rx_aval_cleared", 32'(uart_rx_q.size()), 0);
        chk("rx_read_count", 32'(rx_reads - r0), 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_empty_after_pop", 32'(rx_valid), 0);

        // Receive and transmit pending at the same poll: read comes first
        n = ctrl_strobes;
        for (int i = 0; i < 50 && ctrl_strobes == n; i++) tick();
        w0 = wr_count;
        r0 = rx_reads;
        exp_acc.push_back(1);
        exp_acc.push_back(2);
        exp_rx.push_back(8'h77);
        exp_wdata.push_back(8'h3C);
        uart_rx_q.push_back(8'h77);
        push_tx(8'h3C);
        for (int i = 0; i < 200 && wr_count == w0; i++) tick();
        chk("prio_read_count", 32'(rx_reads - r0), 1);
        chk("prio_write_count", 32'(wr_count - w0), 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (20) tick();

        // RX FIFO full: byte stays in the UART, polling continues
        r0 = rx_reads;
        c0 = ctrl_strobes;
        for (int i = 0; i < 5; i++) begin
            uart_rx_q.push_back(8'(8'h10 + i));
            exp_rx.push_back(8'(8'h10 + i));
            exp_acc.push_back(1);
        end
        repeat (300) tick();
        chk("full_read_count", 32'(rx_reads - r0), 4);
        chk("full_byte_left_in_uart", 32'(uart_rx_q.size()), 1);
        chk("full_polls_continue", 32'(ctrl_strobes - c0 > 10), 1);
        chk("full_tx_ready", 32'(tx_ready), 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        for (int i = 0; i < 100 && uart_rx_q.size() != 0; i++) tick();
        repeat (10) tick();
        chk("resume_read_count", 32'(rx_reads - r0), 5);
        rx_ready = 1'b1;
        repeat (6) tick();
        rx_ready = 1'b0;
        chk("drained_rx_valid", 32'(rx_valid), 0);

        // Read handshake timeout
        e0 = err_count;
        silent = 1'b1;
        for (int i = 0; i < 100 && err_count == e0; i++) tick();
        silent = 1'b0;
        chk("timeout_seen", 32'(err_count - e0), 1);
        chk("timeout_gap", 32'(err_gap), 9);
        chk("timeout_cs_released", 32'(err_cs), 1);
        chk("timeout_pulse_width", 32'(err_timeout), 0);
        repeat (3) tick();
        chk("timeout_repoll", 32'(last_strobe_cyc - err_cyc), 1);
        chk("timeout_single", 32'(err_count - e0), 1);
        repeat (20) tick();

        // Reset during the write settle window with two bytes still queued
        w0 = wr_count;
        exp_acc.push_back(2);
        exp_wdata.push_back(8'hA1);
        tx_valid = 1'b1;
        tx_data  = 8'hA1;
        tick();
        tx_data  = 8'hA2;
        tick();
        tx_data  = 8'hA3;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 100 && wr_count == w0; i++) tick();
        reset = 1'b1;
        tick();
        chk("rst_wr_tx_ready", 32'(tx_ready), 1);
        chk("rst_wr_u_cs", 32'(u_cs), 1);
        chk("rst_wr_u_wr", 32'(u_wr), 1);
        chk("rst_wr_rx_valid", 32'(rx_valid), 0);
        reset = 1'b0;
        repeat (100) tick();
        chk("rst_wr_no_more_writes", 32'(wr_count - w0), 1);

        chk("exp_acc_drained", 32'(exp_acc.size()), 0);
        chk("exp_wdata_drained", 32'(exp_wdata.size()), 0);
        chk("exp_rx_drained", 32'(exp_rx.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_stream_ctrl.md
UART_STREAM_CTRL -- requirements
Module: uart_stream_ctrl

Interface
REQ-001 Parameter TX_DEPTH, default 4, host-to-UART FIFO entries (power of two, >=2).
REQ-002 Parameter RX_DEPTH, default 4, UART-to-host FIFO entries (power of two, >=2).
REQ-003 Parameter RD_TIMEOUT, default 8, maximum cycles to wait for each rd_busy edge.
REQ-004 clock  in  1  system clock; the block uses one clock only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tx_valid / tx_ready / tx_data  in / out / in  1 / 1 / 8  host push port for bytes to transmit.
REQ-007 rx_valid / rx_ready / rx_data  out / in / out  1 / 1 / 8  host pop port for received bytes.
REQ-008 u_cs  out  1  UART chip select, active low.
REQ-009 u_rd_strobe  out  1  read-start pulse to the UART.
REQ-010 u_rd_busy  in  1  UART read busy, active high.
REQ-011 u_wr  out  1  UART write, active low.
REQ-012 u_addr  out  3  UART register address: 0 = control, 1 = rx buffer, 2 = tx buffer.
REQ-013 u_wdata / u_rdata  out / in  8 / 8  UART in_data and out_data.
REQ-014 err_timeout  out  1  one-cycle pulse when a read handshake times out.

Function
REQ-015 FIFOs SHALL be standard valid/ready; transfer occurs when valid & ready at the clock edge.
REQ-016 tx_ready SHALL be 1 exactly when the TX FIFO is not full.
REQ-017 rx_valid SHALL be 1 exactly when the RX FIFO is not empty; rx_data SHALL be the head entry.
REQ-018 Simultaneous push and pop on a full or empty FIFO SHALL be permitted and leave the count unchanged; pointers SHALL wrap modulo depth.
REQ-019 FSM states SHALL be IDLE, RD_STROBE, RD_WAIT_HI, RD_WAIT_LO, RD_HOLD, EVAL, WR, WR_SETTLE.
REQ-020 IDLE SHALL move to RD_STROBE with u_addr=0 (control poll) unconditionally, i.e. polling is continuous.
REQ-021 RD_STROBE SHALL assert u_cs=0 and u_rd_strobe=1 for exactly one cycle, then move to RD_WAIT_HI.
REQ-022 From RD_STROBE through RD_HOLD, u_cs SHALL be 0 and u_addr SHALL be held stable.
REQ-023 RD_WAIT_HI SHALL wait for u_rd_busy=1, then move to RD_WAIT_LO.
REQ-024 RD_WAIT_LO SHALL wait for u_rd_busy=0, then capture u_rdata in that cycle and move to RD_HOLD.
REQ-025 If either wait exceeds RD_TIMEOUT cycles, the FSM SHALL pulse err_timeout, release u_cs and return to IDLE, discarding the read.
REQ-026 RD_HOLD SHALL last one cycle, so the UART completes its post-read clear of RX_AVAL.
REQ-027 After RD_HOLD, a control read SHALL go to EVAL; an rx-buffer read SHALL push the captured byte into the RX FIFO and go to IDLE.
REQ-028 EVAL, first priority: if RX_AVAL=1 and the RX FIFO is not full, issue a read with u_addr=1.
REQ-029 EVAL, second priority: if TX_BUSY=0 and the TX FIFO is not empty, go to WR.
REQ-030 EVAL, otherwise: go to IDLE.
REQ-031 A full RX FIFO SHALL leave the byte in the UART; no read and no drop by this block.
REQ-032 WR SHALL drive u_cs=0, u_wr=0, u_addr=2 and u_wdata=TX FIFO head for exactly one cycle, and pop the TX FIFO.
REQ-033 WR_SETTLE SHALL idle 2 cycles with u_cs=1 so that TX_BUSY is set before the next poll, then go to IDLE.
REQ-034 The block SHALL never write to UART address 0.
REQ-035 Outside the active states, outputs SHALL be: u_cs=1, u_wr=1, u_rd_strobe=0, u_addr=0, u_wdata=0.

Reset
REQ-036 Reset SHALL take priority over all activity.
REQ-037 Reset SHALL force the FSM to IDLE and empty both FIFOs.
REQ-038 Reset SHALL force err_timeout=0 and all UART outputs to their REQ-035 idle values, in the next cycle.
REQ-039 Reset mid-read or mid-write SHALL abort the transaction without any FIFO push or pop.

Structure
REQ-040 The shared UART package SHALL hold the UART register addresses (CTRL=0, RX=1, TX=2).
REQ-041 The shared UART package SHALL hold the control bit indices CTL_RX_AVAL=0, CTL_TX_BUSY=1, CTL_IRQ_ENAB=2.
REQ-042 The shared UART package SHALL hold the FSM state enum.
REQ-043 Both FIFOs SHALL be instances of one sub-module, sync_fifo (parameters WIDTH, DEPTH).

Verification
REQ-044 Scenario: push 0x41 with a UART model where TX_BUSY=0 -> exactly one write, addr=2, wdata=0x41; TX FIFO empty.
REQ-045 Scenario: UART RX_AVAL=1 with rx byte 0x5A -> rx-buffer read; rx_valid=1 with rx_data=0x5A; RX_AVAL observed cleared.
REQ-046 Scenario: RX_AVAL=1 and TX pending at the same poll -> read at addr=1 precedes the write at addr=2.
REQ-047 Scenario: fill the RX FIFO (4 bytes) with rx_ready=0 and RX_AVAL=1 -> no addr=1 reads; control polls continue; after one pop, the read resumes.
REQ-048 Scenario: hold u_rd_busy=0 after the strobe -> err_timeout pulses once after 8 cycles; FSM returns to IDLE.
REQ-049 Scenario: assert reset during WR_SETTLE with 2 bytes queued -> tx_ready=1, FIFO empty, u_cs=1 next cycle.
